// File: rtl/t07_mem_pkg.sv
// Shared types and constants for the CPU-to-Wishbone memory bridge.
// Request encodings, bridge states, timeout default and a bench filler word.
package t07_mem_pkg;

   typedef enum logic [1:0] {
      RWI_IDLE  = 2'b00,
      RWI_READ  = 2'b01,
      RWI_WRITE = 2'b10,
      RWI_FETCH = 2'b11
   } rwi_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } bridge_state_e;

   typedef struct packed {
      rwi_e        typ;
      logic [31:0] adr;
      logic [31:0] dat;
   } req_t;

   localparam int          DEF_TIMEOUT_CYCLES = 64;
   localparam int          DEF_TCW            = 7;
   localparam logic [31:0] DEAD_WORD          = 32'hDEAD_BEEF;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/t07_bus_timeout.sv
// Saturating bus-cycle counter; expired_o flags the enabled cycle that reaches TIMEOUT_CYCLES.
// Combinational expired_o from registered count; clr_i has priority over en_i.
module t07_bus_timeout #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TCW            = 7
) (
   input  logic clk,
   input  logic nrst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TCW-1:0] LIMIT = TCW'(TIMEOUT_CYCLES);

   logic [TCW-1:0] cnt_q;
   logic [TCW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The count holds the cycles already spent, so the current cycle is the last one allowed here.
   assign expired_o = en_i && (cnt_q >= (LIMIT - 1'b1));

endmodule

// File: rtl/t07_cpu_mem_bridge.sv
// Runs each CPU request (fetch/read/write) as one Wishbone classic cycle with a hung-bus timeout.
// Accept to bus is 1 cycle, DONE follows the ack cycle; requests are ignored while busy or in DONE.
module t07_cpu_mem_bridge
   import t07_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int TCW            = DEF_TCW
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [1:0]  rwi_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i
);

   bridge_state_e state_q;
   bridge_state_e state_d;
   req_t          req_q;
   req_t          req_d;
   logic [31:0]   inst_q;
   logic [31:0]   inst_d;
   logic [31:0]   rdata_q;
   logic [31:0]   rdata_d;
   logic          err_q;
   logic          err_d;

   logic in_bus;
   logic tmo_clr;
   logic expired;

   assign in_bus  = (state_q == BUS);
   assign tmo_clr = !in_bus;

   t07_bus_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TCW            (TCW)
   ) u_timeout (
      .clk       (clk),
      .nrst      (nrst),
      .clr_i     (tmo_clr),
      .en_i      (in_bus),
      .expired_o (expired)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (rwi_i != RWI_IDLE) state_d = BUS;
         BUS:     if (wb_ack_i || expired) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch and returned-word capture; ack beats a same-cycle timeout.
   always_comb begin
      req_d   = req_q;
      inst_d  = inst_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      if ((state_q == IDLE) && (rwi_i != RWI_IDLE)) begin
         req_d.typ = rwi_e'(rwi_i);
         req_d.adr = word_align(addr_i);
         req_d.dat = wdata_i;
      end
      if (in_bus) begin
         if (wb_ack_i) begin
            if (req_q.typ == RWI_FETCH) begin
               inst_d = wb_dat_i;
            end else if (req_q.typ == RWI_READ) begin
               rdata_d = wb_dat_i;
            end
         end else if (expired) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         req_q   <= '0;
         inst_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         req_q   <= req_d;
         inst_q  <= inst_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      busy_o   = 1'b0;
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
      wb_we_o  = 1'b0;
      wb_sel_o = 4'h0;
      if (in_bus) begin
         busy_o   = 1'b1;
         wb_cyc_o = 1'b1;
         wb_stb_o = 1'b1;
         wb_we_o  = (req_q.typ == RWI_WRITE);
         wb_sel_o = 4'hF;
      end
   end

   assign wb_adr_o = req_q.adr;
   assign wb_dat_o = req_q.dat;
   assign inst_o   = inst_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_t07_cpu_mem_bridge.sv
// Directed bench for the CPU memory bridge with a transaction-level expectation model.
// Each request has a known bus length, so expected busy/bus/return values follow from the stimulus.
module tb_t07_cpu_mem_bridge;
   import t07_mem_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [1:0]  rwi_i = 2'b00;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] inst_o;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_inst  = '0;
   logic [31:0] m_rdata = '0;
   logic [31:0] m_adr   = '0;
   logic [31:0] m_wdata = '0;
   logic        m_we    = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_err   = 1'b0;
   logic        mon_en  = 1'b0;
   int          bus_starts = 0;
   int          exp_starts = 0;
   logic        cyc_prev = 1'b0;

   t07_cpu_mem_bridge #(.TIMEOUT_CYCLES(TO), .TCW(7)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .rwi_i    (rwi_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .inst_o   (inst_o),
      .rdata_o  (rdata_o),
      .busy_o   (busy_o),
      .err_o    (err_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_sel_o (wb_sel_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      m_err = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", busy_o, m_busy);
         chk("cyc", wb_cyc_o, m_busy);
         chk("stb", wb_stb_o, m_busy);
         chk("err", err_o, m_err);
         chk("inst", inst_o, m_inst);
         chk("rdata", rdata_o, m_rdata);
         if (m_busy) begin
            chk("adr", wb_adr_o, m_adr);
            chk("we", wb_we_o, m_we);
            chk("sel", wb_sel_o, 4'hF);
            if (m_we) chk("dat_o", wb_dat_o, m_wdata);
         end
      end
   end

   always @(posedge clk) begin
      cyc_prev <= wb_cyc_o;
      if (wb_cyc_o && !cyc_prev) bus_starts++;
   end

   // ack_n = BUS cycle carrying the ack (0 = never acked); from_done = called during a DONE cycle.
   task automatic do_txn(input logic [1:0] typ, input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_n, input logic [31:0] rd, input bit hold,
                         input bit from_done, input logic [31:0] lit_adr, input bit lit_en);
      int n_bus;
      rwi_i   = typ;
      addr_i  = addr;
      wdata_i = wd;
      if (from_done) step();
      step();
      exp_starts++;
      m_busy  = 1'b1;
      m_adr   = addr & 32'hFFFF_FFFC;
      m_we    = (typ == 2'b10);
      m_wdata = wd;
      n_bus   = (ack_n != 0) ? ack_n : TO;
      for (int n = 1; n <= n_bus; n++) begin
         if (n == 1 && lit_en) chk("lit_adr", wb_adr_o, lit_adr);
         addr_i  = ~addr;
         wdata_i = ~wd;
         if (n == ack_n) begin
            wb_ack_i = 1'b1;
            wb_dat_i = rd;
         end
         step();
         wb_ack_i = 1'b0;
         wb_dat_i = DEAD_WORD;
      end
      m_busy = 1'b0;
      if (ack_n != 0) begin
         if (typ == 2'b11) m_inst = rd;
         else if (typ == 2'b01) m_rdata = rd;
      end else begin
         m_err = 1'b1;
      end
      rwi_i = hold ? typ : 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 100000", $time);
      $fatal(1);
   end

   initial begin
      #3;
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_cyc", wb_cyc_o, 1'b0);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_sel", wb_sel_o, 4'h0);
      step();
      step();
      nrst   = 1'b1;
      mon_en = 1'b1;
      step();

      do_txn(2'b11, 32'h0000_0010, 32'h0, 3, 32'h0050_0093, 1'b0, 1'b0, 32'h0000_0010, 1'b1);
      chk("fetch_inst_lit", inst_o, 32'h0050_0093);
      chk("fetch_rdata_lit", rdata_o, 32'h0);
      step();

      do_txn(2'b10, 32'h0000_2003, 32'hCAFE_F00D, 1, DEAD_WORD, 1'b0, 1'b0, 32'h0000_2000, 1'b1);
      chk("write_inst_lit", inst_o, 32'h0050_0093);
      step();

      wb_ack_i = 1'b1;
      wb_dat_i = DEAD_WORD;
      step();
      step();
      wb_ack_i = 1'b0;
      chk("stray_ack_rdata_lit", rdata_o, 32'h0);

      do_txn(2'b01, 32'h0000_0104, 32'h0, 2, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0104, 1'b1);
      do_txn(2'b11, 32'h0000_0202, 32'h0, 1, 32'hA5A5_0013, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
      chk("b2b_rdata_lit", rdata_o, 32'h1234_5678);
      chk("b2b_inst_lit", inst_o, 32'hA5A5_0013);
      step();

      do_txn(2'b01, 32'h0000_0300, 32'h0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("timeout_err_lit", err_o, 1'b1);
      chk("timeout_cyc_lit", wb_cyc_o, 1'b0);
      chk("timeout_rdata_lit", rdata_o, 32'h1234_5678);
      step();

      do_txn(2'b01, 32'h0000_0304, 32'h0, TO, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("ack_at_to_err_lit", err_o, 1'b0);
      chk("ack_at_to_rdata_lit", rdata_o, 32'h0BAD_CAFE);
      step();

      rwi_i  = 2'b11;
      addr_i = 32'h0000_0040;
      step();
      exp_starts++;
      m_busy = 1'b1;
      m_adr  = 32'h0000_0040;
      m_we   = 1'b0;
      step();
      #2;
      nrst   = 1'b0;
      mon_en = 1'b0;
      #1;
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_cyc", wb_cyc_o, 1'b0);
      chk("arst_stb", wb_stb_o, 1'b0);
      chk("arst_inst", inst_o, 32'h0);
      chk("arst_rdata", rdata_o, 32'h0);
      chk("arst_adr", wb_adr_o, 32'h0);
      chk("arst_err", err_o, 1'b0);
      rwi_i   = 2'b00;
      m_busy  = 1'b0;
      m_inst  = '0;
      m_rdata = '0;
      step();
      step();
      nrst   = 1'b1;
      mon_en = 1'b1;
      step();

      do_txn(2'b11, 32'h0000_0008, 32'h0, 2, 32'h0000_0013, 1'b0, 1'b0, 32'h0000_0008, 1'b1);
      chk("post_rst_inst_lit", inst_o, 32'h0000_0013);
      step();
      step();

      chk("bus_starts", bus_starts, exp_starts);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
